// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package divider_pkg;

    localparam int DEF_WIDTH = 4;

    // Counter width for a WIDTH-step iteration, never narrower than one bit
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RUN,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, compare, conditionally subtract.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_r,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_r,
    output logic             o_q
);

    // The shifted value needs WIDTH+1 bits; the settled remainder is always
    // below the divisor, so WIDTH bits are enough to carry it between steps.
    logic [WIDTH:0] w_shift;
    logic           w_ge;

    assign w_shift = {i_r, i_bit};
    assign w_ge    = (w_shift >= {1'b0, i_d});

    // Low-bit subtraction is exact because the true difference is < divisor
    assign o_r = w_ge ? (w_shift[WIDTH-1:0] - i_d) : w_shift[WIDTH-1:0];
    assign o_q = w_ge;

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider (2W/W -> W quotient, W remainder), one quotient bit per clock.
// Latency: start accept to done = WIDTH+2 normal (WIDTH+3 with DIV_SIGNED_EN), 2 on error.
// Backpressure: start is only accepted in IDLE or DONE; ignored while busy. Macro: DIV_SIGNED_EN.
module seq_restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [2*WIDTH-1:0]   i_dividend,
    input  logic [WIDTH-1:0]     i_divisor,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [WIDTH-1:0]     o_quotient,
    output logic [WIDTH-1:0]     o_remainder,
    output logic                 o_div_by_zero,
    output logic                 o_overflow
);

    localparam int               CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]     r_dvs;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_q;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_quot;
    logic [WIDTH-1:0]     r_remo;
    logic                 r_dbz;
    logic                 r_ovf;

    logic [2*WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]     w_dvs_mag;
    logic [WIDTH-1:0]     w_dvd_hi;
    logic [WIDTH-1:0]     w_dvd_lo;
    logic [WIDTH-1:0]     w_r_next;
    logic                 w_q_bit;
    logic [WIDTH-1:0]     w_q_final;

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
    logic                 w_neg_q;
    logic                 w_neg_r;
    logic [WIDTH-1:0]     w_q_signed;
    logic [WIDTH-1:0]     w_r_signed;
    logic                 w_fix_ovf;

    // Iteration runs on magnitudes; signs come straight from the captured operands
    assign w_dvd_mag  = r_dvd[2*WIDTH-1] ? -r_dvd : r_dvd;
    assign w_dvs_mag  = r_dvs[WIDTH-1]   ? -r_dvs : r_dvs;
    assign w_neg_q    = r_dvd[2*WIDTH-1] ^ r_dvs[WIDTH-1];
    assign w_neg_r    = r_dvd[2*WIDTH-1];
    assign w_q_signed = w_neg_q ? -r_q : r_q;
    assign w_r_signed = w_neg_r ? -r_rem : r_rem;
    // Negative results may reach -2^(W-1); positive ones stop at 2^(W-1)-1
    assign w_fix_ovf  = w_neg_q ? (r_q > HALF) : (r_q >= HALF);
`else
    assign w_dvd_mag = r_dvd;
    assign w_dvs_mag = r_dvs;
`endif

    assign w_dvd_hi  = w_dvd_mag[2*WIDTH-1:WIDTH];
    assign w_dvd_lo  = w_dvd_mag[WIDTH-1:0];
    assign w_q_final = {r_q[WIDTH-2:0], w_q_bit};

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_r   (r_rem),
        .i_bit (w_dvd_lo[r_cnt]),
        .i_d   (w_dvs_mag),
        .o_r   (w_r_next),
        .o_q   (w_q_bit)
    );

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_remo  <= '0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_dvd   <= i_dividend;
                        r_dvs   <= i_divisor;
                        r_dbz   <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= CHECK;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CHECK: begin
                    if (w_dvs_mag == '0) begin
                        r_dbz   <= 1'b1;
                        r_quot  <= ALL_ONES;
                        r_remo  <= r_dvd[WIDTH-1:0];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (w_dvd_hi >= w_dvs_mag) begin
                        r_ovf   <= 1'b1;
                        r_quot  <= ALL_ONES;
                        r_remo  <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_rem   <= w_dvd_hi;
                        r_q     <= '0;
                        r_cnt   <= CNT_LAST;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_rem <= w_r_next;
                    r_q   <= w_q_final;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
`ifdef DIV_SIGNED_EN
                        r_state <= FIX;
`else
                        r_quot  <= w_q_final;
                        r_remo  <= w_r_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
`endif
                    end
                end
`ifdef DIV_SIGNED_EN
                FIX: begin
                    if (w_fix_ovf) begin
                        r_ovf  <= 1'b1;
                        r_quot <= ALL_ONES;
                        r_remo <= '0;
                    end else begin
                        r_quot <= w_q_signed;
                        r_remo <= w_r_signed;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_quotient    = r_quot;
    assign o_remainder   = r_remo;
    assign o_div_by_zero = r_dbz;
    assign o_overflow    = r_ovf;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (unsigned build, WIDTH=4).
// Expected results come from a behavioural model pushed to a scoreboard queue.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int q;
        int r;
        int dbz;
        int ovf;
        int lat;
    } exp_t;

    exp_t sb[$];

    seq_restoring_divider #(.WIDTH(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .o_busy        (busy),
        .o_done        (done),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_div_by_zero (div_by_zero),
        .o_overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int dvd, input int dvs);
        exp_t e;
        if (dvs == 0) begin
            e.q = 15; e.r = dvd % 16; e.dbz = 1; e.ovf = 0; e.lat = 2;
        end else if ((dvd / 16) >= dvs) begin
            e.q = 15; e.r = 0; e.dbz = 0; e.ovf = 1; e.lat = 2;
        end else begin
            e.q = dvd / dvs; e.r = dvd % dvs; e.dbz = 0; e.ovf = 0; e.lat = 6;
        end
        return e;
    endfunction

    // n counts rising edges from the accepting edge (which is edge 1)
    task automatic wait_done(inout int n);
        while (!done && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string tag, input int n);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_lat"}, n, e.lat);
        chk({tag, "_q"}, int'(quotient), e.q);
        chk({tag, "_r"}, int'(remainder), e.r);
        chk({tag, "_dbz"}, int'(div_by_zero), e.dbz);
        chk({tag, "_ovf"}, int'(overflow), e.ovf);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Called at a falling edge; returns at the falling edge where done is seen
    task automatic run_op(input string tag, input int dvd, input int dvs);
        int n;
        sb.push_back(model(dvd, dvs));
        start    = 1'b1;
        dividend = dvd[7:0];
        divisor  = dvs[3:0];
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check_result(tag, n);
    endtask

    initial begin
        int n;
        int done_cnt;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q", int'(quotient), 0);
        chk("rst_r", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operations
        run_op("op143_13", 143, 13);
        @(negedge clk);
        run_op("op100_7", 100, 7);
        @(negedge clk);
        run_op("op55_0", 55, 0);
        @(negedge clk);
        run_op("op200_3", 200, 3);
        @(negedge clk);
        run_op("op0_5", 0, 5);
        @(negedge clk);
        run_op("op255_0", 255, 0);
        @(negedge clk);
        chk("flags_clear_dbz", int'(div_by_zero), 1);
        run_op("op239_15", 239, 15);
        chk("flags_cleared_dbz", int'(div_by_zero), 0);
        @(negedge clk);

        // Start and new operands during RUN must be ignored
        sb.push_back(model(100, 7));
        start = 1'b1; dividend = 8'd100; divisor = 4'd7;
        @(posedge clk); n = 1;
        @(negedge clk); start = 1'b0;
        repeat (2) begin @(posedge clk); n++; end
        @(negedge clk);
        start = 1'b1; dividend = 8'd143; divisor = 4'd13;
        chk("ign_busy", int'(busy), 1);
        @(posedge clk); n++;
        @(negedge clk); start = 1'b0;
        wait_done(n);
        check_result("ign", n);
        repeat (3) @(negedge clk);
        chk("hold_q", int'(quotient), 14);
        chk("hold_r", int'(remainder), 2);
        chk("hold_done", int'(done), 0);
        chk("hold_busy", int'(busy), 0);

        // Back-to-back: start held high, second op accepted in DONE
        sb.push_back(model(143, 13));
        start = 1'b1; dividend = 8'd143; divisor = 4'd13;
        @(posedge clk); n = 1;
        @(negedge clk);
        dividend = 8'd100; divisor = 4'd7;
        wait_done(n);
        check_result("b2b_first", n);
        sb.push_back(model(100, 7));
        @(posedge clk); n = 1;
        @(negedge clk); start = 1'b0;
        chk("b2b_nogap_busy", int'(busy), 1);
        chk("b2b_q_held", int'(quotient), 11);
        wait_done(n);
        check_result("b2b_second", n);
        @(negedge clk);

        // Asynchronous reset during RUN
        start = 1'b1; dividend = 8'd143; divisor = 4'd13;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_q", int'(quotient), 0);
        chk("arst_r", int'(remainder), 0);
        chk("arst_dbz", int'(div_by_zero), 0);
        chk("arst_ovf", int'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("arst_no_done", done_cnt, 0);
        chk("arst_idle_busy", int'(busy), 0);

        // Multiplier round trip: A*B / B == A, remainder 0
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                sb.push_back(model(a * b, b));
                start = 1'b1; dividend = 8'(a * b); divisor = 4'(b);
                @(posedge clk); n = 1;
                @(negedge clk); start = 1'b0;
                wait_done(n);
                if (sb.size() == 0) begin
                    chk("sweep_sb_empty", 1, 0);
                end else begin
                    void'(sb.pop_front());
                    chk("sweep_done", int'(done), 1);
                    chk("sweep_q", int'(quotient), a);
                    chk("sweep_r", int'(remainder), 0);
                    chk("sweep_lat", n, 6);
                end
            end
        end

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
